// File: rtl/periph_arbiter_pkg.sv
// Shared definitions for the two-master peripheral arbiter and its
// accumulator/counter peripheral register map.
package periph_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam logic [1:0] ADDR_CLR     = 2'b00;
    localparam logic [1:0] ADDR_ACC_ADD = 2'b01;
    localparam logic [1:0] ADDR_ACC_RD  = 2'b10;
    localparam logic [1:0] ADDR_CNT_RD  = 2'b11;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/periph_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: a lone requester wins,
// a tie goes to the master that was not granted last.
module rr_arb2
    import periph_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = M0;
        if (req == 2'b11) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = M1;
        end
    end

endmodule

// File: rtl/periph_arbiter.sv
// Two-master round-robin arbiter/sequencer for the 4-register peripheral:
// one command issued every two cycles, read data routed back to its master.
module periph_arbiter
    import periph_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              p_ce,
    output logic              p_we,
    output logic [ADDR_W-1:0] p_addr,
    output logic [DATA_W-1:0] p_wdata,
    input  logic [DATA_W-1:0] p_rdata,

    output logic [CNT_W-1:0]  m0_cnt,
    output logic [CNT_W-1:0]  m1_cnt,
    output logic              busy
);

    state_t              r_state, w_state_nxt;
    logic                r_last, w_last_nxt;
    logic                r_id, w_id_nxt;
    logic [1:0]          r_gnt, w_gnt_nxt;
    logic [1:0]          r_rvalid, w_rvalid_nxt;
    logic [DATA_W-1:0]   r_m0_rdata, w_m0_rdata_nxt;
    logic [DATA_W-1:0]   r_m1_rdata, w_m1_rdata_nxt;
    logic                r_p_ce, w_p_ce_nxt;
    logic                r_p_we, w_p_we_nxt;
    logic [ADDR_W-1:0]   r_p_addr, w_p_addr_nxt;
    logic [DATA_W-1:0]   r_p_wdata, w_p_wdata_nxt;
    logic [CNT_W-1:0]    r_m0_cnt, w_m0_cnt_nxt;
    logic [CNT_W-1:0]    r_m1_cnt, w_m1_cnt_nxt;
    logic                r_busy, w_busy_nxt;

    logic                w_arb_winner;
    logic                w_arb_valid;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    rr_arb2 u_arb (
        .req    ({m1_req, m0_req}),
        .last   (r_last),
        .winner (w_arb_winner),
        .valid  (w_arb_valid)
    );

    always_comb begin
        w_sel_we    = m0_we;
        w_sel_addr  = m0_addr;
        w_sel_wdata = m0_wdata;
        if (w_arb_winner == M1) begin
            w_sel_we    = m1_we;
            w_sel_addr  = m1_addr;
            w_sel_wdata = m1_wdata;
        end
    end

    // The p_* registers double as the latched command: they hold it for
    // the single ISSUE cycle and return to zero otherwise.
    always_comb begin
        w_state_nxt    = r_state;
        w_last_nxt     = r_last;
        w_id_nxt       = r_id;
        w_gnt_nxt      = '0;
        w_rvalid_nxt   = '0;
        w_m0_rdata_nxt = r_m0_rdata;
        w_m1_rdata_nxt = r_m1_rdata;
        w_p_ce_nxt     = 1'b0;
        w_p_we_nxt     = 1'b0;
        w_p_addr_nxt   = '0;
        w_p_wdata_nxt  = '0;
        w_m0_cnt_nxt   = r_m0_cnt;
        w_m1_cnt_nxt   = r_m1_cnt;
        w_busy_nxt     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_state_nxt   = ISSUE;
                    w_last_nxt    = w_arb_winner;
                    w_id_nxt      = w_arb_winner;
                    w_gnt_nxt     = (w_arb_winner == M1) ? 2'b10 : 2'b01;
                    w_p_ce_nxt    = 1'b1;
                    w_p_we_nxt    = w_sel_we;
                    w_p_addr_nxt  = w_sel_addr;
                    w_p_wdata_nxt = w_sel_wdata;
                    w_busy_nxt    = 1'b1;
                end
            end
            ISSUE: begin
                w_state_nxt = IDLE;
                if (!r_p_we) begin
                    if (r_id == M1) begin
                        w_rvalid_nxt   = 2'b10;
                        w_m1_rdata_nxt = p_rdata;
                    end else begin
                        w_rvalid_nxt   = 2'b01;
                        w_m0_rdata_nxt = p_rdata;
                    end
                end
                if (r_id == M1) begin
                    w_m1_cnt_nxt = r_m1_cnt + 1'b1;
                end else begin
                    w_m0_cnt_nxt = r_m0_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_last     <= M1;
            r_id       <= M0;
            r_gnt      <= '0;
            r_rvalid   <= '0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
            r_p_ce     <= 1'b0;
            r_p_we     <= 1'b0;
            r_p_addr   <= '0;
            r_p_wdata  <= '0;
            r_m0_cnt   <= '0;
            r_m1_cnt   <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_last     <= w_last_nxt;
            r_id       <= w_id_nxt;
            r_gnt      <= w_gnt_nxt;
            r_rvalid   <= w_rvalid_nxt;
            r_m0_rdata <= w_m0_rdata_nxt;
            r_m1_rdata <= w_m1_rdata_nxt;
            r_p_ce     <= w_p_ce_nxt;
            r_p_we     <= w_p_we_nxt;
            r_p_addr   <= w_p_addr_nxt;
            r_p_wdata  <= w_p_wdata_nxt;
            r_m0_cnt   <= w_m0_cnt_nxt;
            r_m1_cnt   <= w_m1_cnt_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign m0_gnt    = r_gnt[0];
    assign m1_gnt    = r_gnt[1];
    assign m0_rvalid = r_rvalid[0];
    assign m1_rvalid = r_rvalid[1];
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign p_ce      = r_p_ce;
    assign p_we      = r_p_we;
    assign p_addr    = r_p_addr;
    assign p_wdata   = r_p_wdata;
    assign m0_cnt    = r_m0_cnt;
    assign m1_cnt    = r_m1_cnt;
    assign busy      = r_busy;

endmodule

// File: tb/tb_periph_arbiter.sv
// Bench for periph_arbiter: table-driven single-master transactions, a
// contention run, reset during ISSUE, and counter wrap on a CNT_W=4 copy.
module tb_periph_arbiter;
    import periph_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [1:0]  m0_addr = '0;
    logic [31:0] m0_wdata = '0;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [1:0]  m1_addr = '0;
    logic [31:0] m1_wdata = '0;
    logic [31:0] p_rdata;

    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        p_ce, p_we, busy;
    logic [1:0]  p_addr;
    logic [31:0] p_wdata;
    logic [15:0] m0_cnt, m1_cnt;

    logic        w4_m0_gnt, w4_m0_rvalid, w4_m1_gnt, w4_m1_rvalid;
    logic [31:0] w4_m0_rdata, w4_m1_rdata;
    logic        w4_p_ce, w4_p_we, w4_busy;
    logic [1:0]  w4_p_addr;
    logic [31:0] w4_p_wdata;
    logic [3:0]  w4_m0_cnt, w4_m1_cnt;

    always #5 clk = ~clk;

    periph_arbiter u_dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .p_ce(p_ce), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata), .p_rdata(p_rdata),
        .m0_cnt(m0_cnt), .m1_cnt(m1_cnt), .busy(busy)
    );

    periph_arbiter #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(w4_m0_gnt), .m0_rvalid(w4_m0_rvalid), .m0_rdata(w4_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(w4_m1_gnt), .m1_rvalid(w4_m1_rvalid), .m1_rdata(w4_m1_rdata),
        .p_ce(w4_p_ce), .p_we(w4_p_we), .p_addr(w4_p_addr), .p_wdata(w4_p_wdata), .p_rdata(p_rdata),
        .m0_cnt(w4_m0_cnt), .m1_cnt(w4_m1_cnt), .busy(w4_busy)
    );

    // Behavioural accumulator/counter peripheral; p_rdata is zero unless read.
    logic [31:0] pm_acc;
    logic [15:0] pm_adds;

    always_comb begin
        p_rdata = '0;
        if (p_ce && !p_we) begin
            case (p_addr)
                ADDR_ACC_RD: p_rdata = pm_acc;
                ADDR_CNT_RD: p_rdata = {16'hA5A5, pm_adds};
                default:     p_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (p_ce && p_we) begin
            case (p_addr)
                ADDR_CLR: begin
                    pm_acc  <= '0;
                    pm_adds <= '0;
                end
                ADDR_ACC_ADD: begin
                    pm_acc  <= pm_acc + p_wdata;
                    pm_adds <= pm_adds + 1'b1;
                end
                default: ;
            endcase
        end
    end

    typedef struct {
        logic        m;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [15:0] exp_cnt0;
        logic [15:0] exp_cnt1;
    } vec_t;

    typedef struct {
        logic        m;
        logic [31:0] data;
    } rsp_t;

    rsp_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard: every read response must match the oldest pushed expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (!p_ce) chk("p_quiet", {p_we, p_addr, p_wdata}, 64'd0);
            if (m0_rvalid || m1_rvalid) begin
                if (exp_q.size() == 0) begin
                    chk("rvalid_unexpected", {m1_rvalid, m0_rvalid}, 64'd0);
                end else begin
                    rsp_t r;
                    r = exp_q.pop_front();
                    chk("rvalid_who", {m1_rvalid, m0_rvalid}, r.m ? 64'd2 : 64'd1);
                    chk("rdata", r.m ? m1_rdata : m0_rdata, r.data);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        m0_req = 1'b0;
        m1_req = 1'b0;
        reset  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drive(input logic m, input logic req, input logic we,
                         input logic [1:0] addr, input logic [31:0] wdata);
        if (m == M1) begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        bit got;
        got = 1'b0;
        drive(v.m, 1'b1, v.we, v.addr, v.wdata);
        if (!v.we) exp_q.push_back('{m: v.m, data: v.exp_rdata});
        for (int i = 0; i < 8 && !got; i++) begin
            cyc();
            if (m0_gnt || m1_gnt) begin
                got = 1'b1;
                chk({tag, "_gnt"}, {m1_gnt, m0_gnt}, v.m ? 64'd2 : 64'd1);
                chk({tag, "_pcmd"}, {busy, p_ce, p_we, p_addr, p_wdata},
                    {1'b1, 1'b1, v.we, v.addr, v.wdata});
            end
        end
        chk({tag, "_gnt_seen"}, got, 1);
        drive(v.m, 1'b0, 1'b0, 2'b00, 32'd0);
        cyc();
        chk({tag, "_cnt"}, {m1_cnt, m0_cnt}, {v.exp_cnt1, v.exp_cnt0});
        chk({tag, "_after"}, {busy, p_ce, m0_gnt, m1_gnt}, 64'd0);
    endtask

    vec_t vecs[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit got;
        vecs[0] = '{M0, 1'b1, ADDR_CLR,     32'd0, 32'd0,          16'd1, 16'd0};
        vecs[1] = '{M0, 1'b1, ADDR_ACC_ADD, 32'd5, 32'd0,          16'd2, 16'd0};
        vecs[2] = '{M0, 1'b1, ADDR_ACC_ADD, 32'd7, 32'd0,          16'd3, 16'd0};
        vecs[3] = '{M0, 1'b0, ADDR_ACC_RD,  32'd0, 32'd12,         16'd4, 16'd0};
        vecs[4] = '{M1, 1'b0, ADDR_CNT_RD,  32'd0, 32'hA5A5_0002,  16'd4, 16'd1};

        // Reset and idle
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("idle_ctrl", {m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, p_ce, p_we, p_addr, busy,
                              m0_cnt, m1_cnt}, 64'd0);
            chk("idle_data", {m0_rdata, m1_rdata}, 64'd0);
        end

        // Table-driven single-master transactions
        for (int i = 0; i < 5; i++) begin
            do_txn(vecs[i], $sformatf("vec%0d", i));
        end
        @(negedge clk); #1;
        chk("table_q_empty", exp_q.size(), 0);
        chk("m0_rdata_hold", m0_rdata, 32'd12);

        // Contention: both masters hold read requests
        do_reset();
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back('{m: (k % 2 == 1), data: (k % 2 == 1) ? 32'hA5A5_0002 : 32'd12});
        end
        drive(M0, 1'b1, 1'b0, ADDR_ACC_RD, 32'd0);
        drive(M1, 1'b1, 1'b0, ADDR_CNT_RD, 32'd0);
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk($sformatf("cont_gnt%0d", k), {m1_gnt, m0_gnt}, (k % 2 == 1) ? 64'd2 : 64'd1);
            chk($sformatf("cont_addr%0d", k), {p_ce, p_addr},
                (k % 2 == 1) ? {1'b1, ADDR_CNT_RD} : {1'b1, ADDR_ACC_RD});
            if (k == 4) m0_req = 1'b0;
            if (k == 5) m1_req = 1'b0;
            cyc();
            chk($sformatf("cont_gap%0d", k), {p_ce, m0_gnt, m1_gnt}, 64'd0);
        end
        @(negedge clk); #1;
        chk("cont_q_empty", exp_q.size(), 0);
        chk("cont_cnts", {m1_cnt, m0_cnt}, {16'd3, 16'd3});

        // Reset during an ISSUE read discards the response
        drive(M0, 1'b1, 1'b0, ADDR_ACC_RD, 32'd0);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            cyc();
            got = m0_gnt;
        end
        chk("rst_issue_gnt", {got, p_ce}, 64'd3);
        reset  = 1'b1;
        m0_req = 1'b0;
        cyc();
        reset = 1'b0;
        chk("rst_outputs", {p_ce, m0_rvalid, m1_rvalid, busy, m0_gnt, m1_gnt}, 64'd0);
        chk("rst_cnts", {m1_cnt, m0_cnt, w4_m1_cnt, w4_m0_cnt}, 64'd0);
        cyc();
        chk("rst_no_rvalid", {m0_rvalid, m1_rvalid}, 64'd0);

        // First tie after reset goes to m0
        exp_q.push_back('{m: M0, data: 32'd12});
        exp_q.push_back('{m: M1, data: 32'hA5A5_0002});
        drive(M0, 1'b1, 1'b0, ADDR_ACC_RD, 32'd0);
        drive(M1, 1'b1, 1'b0, ADDR_CNT_RD, 32'd0);
        cyc();
        chk("post_rst_tie", {m1_gnt, m0_gnt}, 64'd1);
        m0_req = 1'b0;
        cyc();
        cyc();
        chk("post_rst_m1", {m1_gnt, m0_gnt}, 64'd2);
        m1_req = 1'b0;
        cyc();
        @(negedge clk); #1;
        chk("rst_q_empty", exp_q.size(), 0);

        // Counter wrap on the CNT_W=4 copy after 17 transactions
        do_reset();
        for (int i = 0; i < 17; i++) begin
            vec_t v;
            v = '{M0, 1'b1, ADDR_ACC_ADD, 32'd0, 32'd0, 16'(i + 1), 16'd0};
            do_txn(v, $sformatf("wrap%0d", i));
        end
        chk("wrap_cnt4", w4_m0_cnt, 4'd1);
        chk("wrap_cnt16", m0_cnt, 16'd17);

        repeat (3) cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/periph_arbiter.md
Name: periph_arbiter

Overview:
- Two-master round-robin arbiter and sequencer for the 4-register memory-mapped accumulator/counter peripheral.
- Sits between the CPU load/store port (master 0) and a second requester, e.g. a debug or DMA port (master 1).
- Registers the winning command and drives the peripheral's ce/we/addr/wdata for exactly one cycle.
- For reads, captures the peripheral's rdata and returns it to the requesting master with a valid strobe.

Parameters:
- DATA_W, 32, width of write/read data.
- ADDR_W, 2, peripheral register address width.
- CNT_W, 16, width of per-master completed-transaction counters.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- m0_req  input  1  master 0 request; held with command until m0_gnt.
- m0_we  input  1  master 0 write (1) / read (0).
- m0_addr  input  ADDR_W  master 0 register address.
- m0_wdata  input  DATA_W  master 0 write data.
- m0_gnt  output  1  one-cycle pulse: master 0 command accepted.
- m0_rvalid  output  1  one-cycle pulse: m0_rdata valid.
- m0_rdata  output  DATA_W  master 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1.
- p_ce  output  1  peripheral chip enable.
- p_we  output  1  peripheral write enable.
- p_addr  output  ADDR_W  peripheral address.
- p_wdata  output  DATA_W  peripheral write data.
- p_rdata  input  DATA_W  peripheral read data; valid in the same cycle p_ce=1 and p_we=0.
- m0_cnt, m1_cnt  output  CNT_W  completed transactions per master.
- busy  output  1  high while state is ISSUE.

Behaviour:
- All outputs are registered. On reset, every output is 0, state is IDLE, and last_gnt=1 so master 0 wins the first tie.
- FSM states: IDLE, ISSUE.
- IDLE:
  - If any req is high, select a winner and latch its we/addr/wdata and master id.
  - Pulse that master's gnt for this cycle (registered, so visible the cycle after req is sampled).
  - Go to ISSUE. With no req, stay in IDLE and hold p_ce=0.
- ISSUE:
  - Drive p_ce=1 with the latched p_we/p_addr/p_wdata for exactly one cycle.
  - If the command is a read, capture p_rdata into the winner's mN_rdata at the end of this cycle.
  - Increment the winner's counter (wraps at 2^CNT_W) and return to IDLE.
- Read response: mN_rvalid pulses for one cycle, the cycle after ISSUE. mN_rdata holds its value until the next read for that master. Writes produce no rvalid.
- Arbitration:
  - Only one req high: that master wins.
  - Both high: the master other than last_gnt wins; last_gnt updates on each grant.
  - Result: strict alternation under continuous contention.
- Throughput is one transaction per 2 cycles. The rvalid of transaction N coincides with the IDLE/grant cycle of transaction N+1.
- p_we, p_addr and p_wdata are 0 whenever p_ce=0, so the peripheral never sees stale commands.
- A master must hold its command stable from req assertion until its gnt pulse. It may drop req, or present a new command, in the cycle after gnt.
- A req still high after gnt is treated as a new request.
- Reset asserted mid-ISSUE: p_ce drops to 0 the next cycle, the pending rvalid and counter increment are discarded, and the FSM enters IDLE.
- Address and data pass through unmodified (no width conversion).

Decomposition:
- Shared package holds:
  - state encoding constants IDLE and ISSUE;
  - peripheral register addresses ADDR_CLR=2'b00, ADDR_ACC_ADD=2'b01, ADDR_ACC_RD=2'b10, ADDR_CNT_RD=2'b11;
  - master id constants M0=1'b0, M1=1'b1.
- One natural sub-module: rr_arb2, a combinational 2-way round-robin picker with inputs req[1:0] and last and outputs winner and valid.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, p_ce never asserted.
- m0: write addr0, write addr1 wdata=5, write addr1 wdata=7, read addr2 -> m0_rvalid one pulse with m0_rdata=12; m0_cnt=4; no m1 activity.
- m0 and m1 both hold req with reads for 6 transactions -> grants alternate m0, m1, m0, m1, m0, m1. Each p_ce pulse is separated by 1 idle cycle. rvalid goes only to the matching master.
- m1 read addr3 while m0 idle -> m1_gnt, then p_ce with p_addr=3 and p_we=0, then m1_rvalid with m1_rdata equal to the stimulus p_rdata value (e.g. 32'hA5A5_0003). m0_rvalid stays 0.
- Reset asserted during an ISSUE read -> no rvalid, counters 0, p_ce=0 the next cycle. The next request after reset is granted to m0 on a tie.
- Set counter near wrap (CNT_W=4 build), issue 17 m0 transactions -> m0_cnt=1.
